// File: rtl/note_seq_pkg.sv
// Shared types and constants for the note sequencing controller.
// The melody ROM constants are only consumed when NOTE_SEQ_MELODY_EN is defined.
package note_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LIVE = 2'd1,
        ST_PLAY = 2'd2,
        ST_GAP  = 2'd3
    } note_seq_state_t;

    localparam logic [7:0] NOTE_OFF = 8'd0;

    // KEY1..KEY4 note map, index 0 has the highest priority
    localparam logic [7:0] KEY_NOTE [4] = '{8'd60, 8'd62, 8'd64, 8'd65};

    localparam int unsigned MELODY_LEN = 8;
    localparam logic [2:0]  MELODY_LAST = 3'(MELODY_LEN - 1);
    localparam logic [7:0]  MELODY [MELODY_LEN] =
        '{8'd60, 8'd62, 8'd64, 8'd65, 8'd67, 8'd65, 8'd64, 8'd62};

    // Fixed-priority key arbitration: KEY1 > KEY2 > KEY3 > KEY4
    function automatic logic [7:0] arb_note(input logic [3:0] keys_pressed);
        logic [7:0] note;
        note = NOTE_OFF;
        if (keys_pressed[0])      note = KEY_NOTE[0];
        else if (keys_pressed[1]) note = KEY_NOTE[1];
        else if (keys_pressed[2]) note = KEY_NOTE[2];
        else if (keys_pressed[3]) note = KEY_NOTE[3];
        return note;
    endfunction

endpackage

// File: rtl/note_seq_ctrl_key_debounce.sv
// Single-key 2-flop synchronizer plus stability counter.
// Output is in pressed polarity (1 = pressed) regardless of P_KEY_ACT.
module key_debounce #(
    parameter logic        P_KEY_ACT      = 1'b0,
    parameter int unsigned P_DEBOUNCE_CYC = 500000
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic reset,
    input  logic en,
    input  logic key_raw,
    output logic key_db
);

    localparam int unsigned          LP_CNT_W    = $clog2(P_DEBOUNCE_CYC + 1);
    localparam logic [LP_CNT_W-1:0]  LP_CNT_LAST = LP_CNT_W'(P_DEBOUNCE_CYC - 1);

    logic                r_sync1;
    logic                r_sync2;
    logic [LP_CNT_W-1:0] r_cnt;
    logic                r_db;
    logic                w_pressed;

    // Two-stage synchronizer, reset to the released level
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_sync1 <= ~P_KEY_ACT;
            r_sync2 <= ~P_KEY_ACT;
        end else if (reset) begin
            r_sync1 <= ~P_KEY_ACT;
            r_sync2 <= ~P_KEY_ACT;
        end else if (en) begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = (r_sync2 == P_KEY_ACT);

    // Accept a new level after P_DEBOUNCE_CYC consecutive samples that differ from the held one
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (reset) begin
            r_cnt <= '0;
            r_db  <= 1'b0;
        end else if (en) begin
            if (w_pressed == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == LP_CNT_LAST) begin
                r_db  <= w_pressed;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + LP_CNT_W'(1);
            end
        end
    end

    assign key_db = r_db;

endmodule

// File: rtl/note_seq_ctrl.sv
// Note selection controller: debounced, priority-arbitrated live keys and an
// optional stored 8-step melody. Melody support is compiled in only when
// NOTE_SEQ_MELODY_EN is defined; otherwise the FSM uses IDLE/LIVE only.
module note_seq_ctrl
    import note_seq_pkg::*;
#(
    parameter logic        P_KEY_ACT      = 1'b0,
    parameter int unsigned P_DEBOUNCE_CYC = 500000,
    parameter int unsigned P_STEP_CYC     = 12500000,
    parameter int unsigned P_GAP_CYC      = 1250000
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic       reset,
    input  logic       en,
    input  logic [3:0] keys,
    input  logic       play_start,
    output logic [7:0] note_select,
    output logic       busy,
    output logic [3:0] keys_db
);

    logic [3:0]      w_keys_db;
    logic            w_any_key;
    note_seq_state_t r_state;
    note_seq_state_t w_state_nxt;
    logic [7:0]      r_note;
    logic [7:0]      w_note_nxt;

    for (genvar gi = 0; gi < 4; gi++) begin : g_key
        key_debounce #(
            .P_KEY_ACT      (P_KEY_ACT),
            .P_DEBOUNCE_CYC (P_DEBOUNCE_CYC)
        ) u_key_debounce (
            .aclk    (aclk),
            .aresetn (aresetn),
            .reset   (reset),
            .en      (en),
            .key_raw (keys[gi]),
            .key_db  (w_keys_db[gi])
        );
    end

    assign w_any_key = |w_keys_db;

`ifdef NOTE_SEQ_MELODY_EN
    localparam int unsigned LP_DUR_MAX = (P_STEP_CYC > P_GAP_CYC) ? P_STEP_CYC : P_GAP_CYC;
    localparam int unsigned LP_DUR_W   = $clog2(LP_DUR_MAX + 1);

    logic [LP_DUR_W-1:0] r_cnt;
    logic [LP_DUR_W-1:0] w_cnt_nxt;
    logic [2:0]          r_step;
    logic [2:0]          w_step_nxt;
    logic                w_step_done;
    logic                w_gap_done;

    assign w_step_done = (r_cnt == LP_DUR_W'(P_STEP_CYC - 1));
    assign w_gap_done  = (r_cnt == LP_DUR_W'(P_GAP_CYC - 1));
`else
    logic w_unused_cfg;
    assign w_unused_cfg = ^{play_start, (P_STEP_CYC > 0), (P_GAP_CYC > 0)};
`endif

    // Next state, step, duration count and registered note value
    always_comb begin
        w_state_nxt = r_state;
        w_note_nxt  = NOTE_OFF;
`ifdef NOTE_SEQ_MELODY_EN
        w_step_nxt  = r_step;
        w_cnt_nxt   = '0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_any_key) begin
                    w_state_nxt = ST_LIVE;
`ifdef NOTE_SEQ_MELODY_EN
                end else if (play_start) begin
                    w_state_nxt = ST_PLAY;
                    w_step_nxt  = '0;
`endif
                end
            end
            ST_LIVE: begin
                if (!w_any_key) w_state_nxt = ST_IDLE;
            end
`ifdef NOTE_SEQ_MELODY_EN
            ST_PLAY: begin
                if (w_any_key) begin
                    w_state_nxt = ST_LIVE;
                    w_step_nxt  = '0;
                end else if (w_step_done) begin
                    w_state_nxt = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_any_key) begin
                    w_state_nxt = ST_LIVE;
                    w_step_nxt  = '0;
                end else if (w_gap_done) begin
                    // step wraps 7 -> 0 on the same edge that returns to IDLE
                    w_step_nxt  = r_step + 3'd1;
                    w_state_nxt = (r_step == MELODY_LAST) ? ST_IDLE : ST_PLAY;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase

`ifdef NOTE_SEQ_MELODY_EN
        if ((w_state_nxt == r_state) && ((r_state == ST_PLAY) || (r_state == ST_GAP)))
            w_cnt_nxt = r_cnt + LP_DUR_W'(1);
`endif

        case (w_state_nxt)
            ST_LIVE: w_note_nxt = arb_note(w_keys_db);
`ifdef NOTE_SEQ_MELODY_EN
            ST_PLAY: w_note_nxt = MELODY[w_step_nxt];
`endif
            default: w_note_nxt = NOTE_OFF;
        endcase
    end

    // State, note and melody registers; en gates every update
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
            r_note  <= NOTE_OFF;
`ifdef NOTE_SEQ_MELODY_EN
            r_step  <= '0;
            r_cnt   <= '0;
`endif
        end else if (reset) begin
            r_state <= ST_IDLE;
            r_note  <= NOTE_OFF;
`ifdef NOTE_SEQ_MELODY_EN
            r_step  <= '0;
            r_cnt   <= '0;
`endif
        end else if (en) begin
            r_state <= w_state_nxt;
            r_note  <= w_note_nxt;
`ifdef NOTE_SEQ_MELODY_EN
            r_step  <= w_step_nxt;
            r_cnt   <= w_cnt_nxt;
`endif
        end
    end

    assign note_select = r_note;
    assign busy        = (r_state != ST_IDLE);
    assign keys_db     = w_keys_db;

endmodule

// File: tb/tb_note_seq_ctrl.sv
// Testbench for note_seq_ctrl with a time-based reference model.
// Melody-specific steps are compiled when NOTE_SEQ_MELODY_EN is defined.
module tb_note_seq_ctrl;

    localparam int unsigned DB  = 4;
    localparam int unsigned SC  = 8;
    localparam int unsigned GC  = 2;
    localparam int unsigned PER = SC + GC;
`ifdef NOTE_SEQ_MELODY_EN
    localparam bit MEL_ON = 1'b1;
`else
    localparam bit MEL_ON = 1'b0;
`endif
    localparam int M_IDLE = 0;
    localparam int M_LIVE = 1;
    localparam int M_MEL  = 2;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic       reset;
    logic       en;
    logic [3:0] keys;
    logic       play_start;
    logic [7:0] note_select;
    logic       busy;
    logic [3:0] keys_db;

    note_seq_ctrl #(
        .P_KEY_ACT      (1'b0),
        .P_DEBOUNCE_CYC (DB),
        .P_STEP_CYC     (SC),
        .P_GAP_CYC      (GC)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .reset       (reset),
        .en          (en),
        .keys        (keys),
        .play_start  (play_start),
        .note_select (note_select),
        .busy        (busy),
        .keys_db     (keys_db)
    );

    always #5 aclk = ~aclk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int REF_MEL [8] = '{60, 62, 64, 65, 67, 65, 64, 62};
    int REF_KEY [4] = '{60, 62, 64, 65};

    logic [3:0] m_hist [$];
    logic [3:0] m_db;
    int         m_mode;
    int         m_t;
    logic [7:0] m_note;
    bit         m_busy;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        assert (obs === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, want);
        end
    endtask

    function automatic logic [7:0] mel_note(input int t);
        if ((t % PER) < SC) return 8'(REF_MEL[t / PER]);
        return 8'd0;
    endfunction

    function automatic logic [7:0] ref_arb(input logic [3:0] pressed);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 3; i >= 0; i--) if (pressed[i]) n = 8'(REF_KEY[i]);
        return n;
    endfunction

    function automatic void model_reset();
        m_hist = {};
        for (int i = 0; i < DB + 2; i++) m_hist.push_back(4'b0000);
        m_db   = 4'b0000;
        m_mode = M_IDLE;
        m_t    = 0;
        m_note = 8'd0;
        m_busy = 1'b0;
    endfunction

    // One enabled clock edge: controller reacts to the debounced state held before the edge
    function automatic void model_edge(input logic [3:0] raw, input bit ps);
        logic [3:0] db_old;
        bit         same;
        db_old = m_db;
        if (db_old != 4'b0000) begin
            m_mode = M_LIVE;
            m_t    = 0;
            m_note = ref_arb(db_old);
        end else if (m_mode == M_LIVE) begin
            m_mode = M_IDLE;
            m_note = 8'd0;
        end else if (m_mode == M_IDLE) begin
            if (ps && MEL_ON) begin
                m_mode = M_MEL;
                m_t    = 0;
                m_note = mel_note(0);
            end else begin
                m_note = 8'd0;
            end
        end else begin
            m_t++;
            if (m_t >= 8 * PER) begin
                m_mode = M_IDLE;
                m_note = 8'd0;
            end else begin
                m_note = mel_note(m_t);
            end
        end
        m_busy = (m_mode != M_IDLE);
        // newest raw sample at index 0; synchronized level lags by two samples
        m_hist.push_front(~raw);
        void'(m_hist.pop_back());
        for (int k = 0; k < 4; k++) begin
            same = 1'b1;
            for (int j = 3; j <= DB + 1; j++)
                if (m_hist[j][k] != m_hist[2][k]) same = 1'b0;
            if (same) m_db[k] = m_hist[2][k];
        end
    endfunction

    task automatic tick();
        logic [3:0] k;
        bit ps, e, r;
        k = keys; ps = play_start; e = en; r = reset;
        @(posedge aclk);
        #1;
        if (!aresetn || r) model_reset();
        else if (e) model_edge(k, ps);
        check("note_select", 32'(note_select), 32'(m_note));
        check("busy", 32'(busy), 32'(m_busy));
        check("keys_db", 32'(keys_db), 32'(m_db));
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin tick(); n++; end
        check("idle_reached", 32'(busy), 32'd0);
    endtask

    initial begin
        int lat;
        int n62;
        int hold;
        logic [7:0] rec [80];

        aresetn = 1'b0; reset = 1'b0; en = 1'b1; keys = 4'hF; play_start = 1'b0;
        model_reset();
        repeat (3) tick();
        check("rst_note", 32'(note_select), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_keys_db", 32'(keys_db), 32'd0);
        aresetn = 1'b1;

        // 1: idle after reset
        repeat (50) tick();
        check("idle50_note", 32'(note_select), 32'd0);

        // 2: KEY3 latency and release
        keys = 4'b1011;
        lat = 0;
        while (keys_db !== 4'b0100 && lat < 20) begin tick(); lat++; end
        check("key3_db_latency", 32'(lat), 32'd6);
        tick();
        check("key3_note", 32'(note_select), 32'd64);
        keys = 4'hF;
        lat = 0;
        while (note_select !== 8'd0 && lat < 20) begin tick(); lat++; end
        check("key3_release_latency", 32'(lat), 32'd7);

        // 3: bouncing KEY1 never accepted, then KEY1+KEY4 resolves to KEY1
        for (int j = 0; j < 30; j++) begin
            keys = {3'b111, ((j / 3) % 2 == 0) ? 1'b0 : 1'b1};
            tick();
        end
        check("bounce_db0", 32'(keys_db[0]), 32'd0);
        keys = 4'b0110;
        repeat (8) tick();
        check("key1_key4_note", 32'(note_select), 32'd60);
        keys = 4'hF;
        wait_idle(20);
        repeat (5) tick();

`ifdef NOTE_SEQ_MELODY_EN
        // 4: full melody, second play_start ignored
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        rec[0] = note_select;
        for (int k = 1; k < 80; k++) begin
            if (k == 30) play_start = 1'b1;
            tick();
            play_start = 1'b0;
            rec[k] = note_select;
        end
        for (int k = 0; k < 80; k++)
            check("melody_seq", 32'(rec[k]), ((k % 10) < 8) ? 32'(REF_MEL[k / 10]) : 32'd0);
        tick();
        check("melody_end_busy", 32'(busy), 32'd0);
        repeat (5) tick();

        // 5: KEY2 during step 3 aborts the melody
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        repeat (31) tick();
        keys = 4'b1101;
        lat = 0;
        while (keys_db !== 4'b0010 && lat < 20) begin tick(); lat++; end
        tick();
        check("abort_note", 32'(note_select), 32'd62);
        keys = 4'hF;
        wait_idle(20);
        repeat (20) tick();
        check("no_resume_note", 32'(note_select), 32'd0);

        // 6a: async reset mid-PLAY silences at once
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        repeat (14) tick();
        aresetn = 1'b0;
        #1;
        check("areset_immediate", 32'(note_select), 32'd0);
        model_reset();
        tick();
        aresetn = 1'b1;
        repeat (3) tick();

        // 6b: five disabled cycles stretch step 1 to 13 wall cycles
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        n62 = 0;
        for (int j = 1; j < 30; j++) begin
            en = (j >= 12 && j < 17) ? 1'b0 : 1'b1;
            tick();
            if (note_select === 8'd62) n62++;
        end
        en = 1'b1;
        check("en_stretch_len", 32'(n62), 32'd13);
        wait_idle(100);
`else
        play_start = 1'b1;
        tick();
        play_start = 1'b0;
        repeat (10) tick();
        check("nomel_busy", 32'(busy), 32'd0);
        check("nomel_note", 32'(note_select), 32'd0);
`endif

        // Randomized traffic against the model
        hold = 0;
        for (int c = 0; c < 800; c++) begin
            if (hold == 0) begin
                keys = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
                hold = $urandom_range(1, 15);
            end
            hold--;
            play_start = ($urandom_range(0, 19) == 0);
            en         = ($urandom_range(0, 9) != 0);
            reset      = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0; play_start = 1'b0; en = 1'b1; keys = 4'hF;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
